rd_pntrs_and_empty: RTL and testbench
=====================================

Name: rd_pntrs_and_empty

Overview:
Read-domain control stage of the dual-clock FIFO. It consumes the Gray-coded write pointer produced by the write-pointer/full stage and resynchronises it into the read clock. It maintains the binary and Gray read pointers and produces the registered empty flag, used-words count, almost-empty and sticky underflow. Its Gray read pointer output feeds back to the write-side full logic.

Parameters:
DWIDTH, 8, data width (carried for hierarchy consistency, no logic depends on it)
AWIDTH, 4, RAM address width; FIFO depth = 2**AWIDTH; pointers are AWIDTH+1 bits
AE_LVL, 2, almost-empty threshold in words, legal range 0..2**AWIDTH

Ports:
rd_clk_i  input  1  read-domain clock, rising edge
aclr_i  input  1  asynchronous active-high reset
rd_req_i  input  1  read request; honoured only when rd_empty_o=0
wr_pntr_gray_i  input  AWIDTH+1  Gray write pointer from the write clock domain (asynchronous to rd_clk_i)
rd_pntr_o  output  AWIDTH  RAM read address = rd_pntr_bin[AWIDTH-1:0]
rd_pntr_gray_wr_o  output  AWIDTH+1  registered Gray read pointer, consumed by the write-side full logic
rd_empty_o  output  1  registered empty flag
rd_almost_empty_o  output  1  rd_usedw_o <= AE_LVL
rd_usedw_o  output  AWIDTH+1  words available, 0..2**AWIDTH
rd_underflow_o  output  1  sticky: a read was attempted while empty

Behaviour:
- Clock and reset: one clock, rd_clk_i. aclr_i is asynchronous and active-high. Every flop clears on aclr_i without needing a clock edge.
- Reset values:
  - rd_pntr_bin, both sync stages, rd_pntr_gray_wr_o, rd_usedw_o, rd_underflow_o = 0.
  - rd_empty_o = 1.
  - rd_almost_empty_o = 1.
- Synchroniser: two flop stages, sync1 <= wr_pntr_gray_i, then sync2 <= sync1. No logic is placed between the stages.
- Gray to binary: wr_bin_sync[i] = XOR of sync2[AWIDTH:i], for i = 0..AWIDTH.
- Read pointer:
  - rd_pntr_bin_next = rd_pntr_bin + (rd_req_i & ~rd_empty_o), modulo 2**(AWIDTH+1). The full wrap is 2**(AWIDTH+1)-1 -> 0.
  - rd_pntr_gray_next = rd_pntr_bin_next ^ (rd_pntr_bin_next >> 1).
  - On each edge: rd_pntr_bin <= rd_pntr_bin_next and rd_pntr_gray_wr_o <= rd_pntr_gray_next.
- Empty: rd_empty_o <= (rd_pntr_gray_next == sync2).
  - A read that drains the last word sets empty on that same edge, with zero lag.
- Write visibility latency: after wr_pntr_gray_i changes (setup met), sync2 updates on the 2nd rd_clk edge and rd_empty_o falls on the 3rd.
- Used words: rd_usedw_o = (wr_bin_sync - rd_pntr_bin) modulo 2**(AWIDTH+1), combinational from registers. It is never negative and reads 2**AWIDTH when full.
- Almost empty: rd_almost_empty_o = (rd_usedw_o <= AE_LVL), combinational.
- Underflow: rd_req_i=1 while rd_empty_o=1 leaves the pointer unchanged and sets rd_underflow_o on that edge. It clears only on aclr_i.
- Simultaneous events:
  - A read and a synchronised write in the same cycle: empty evaluates the next read pointer against the new sync2. A stale sync2 can only over-report empty, never under-report it.
  - rd_req_i held high while empty: no pointer movement, underflow set.
- Reset mid-operation: all outputs return to their reset values immediately. After aclr_i deasserts, operation resumes on the next edge from pointer 0.
- Timing: rd_pntr_gray_wr_o is a direct flop output with no combinational logic after it, which makes it safe for CDC into the write domain.

Test Plan:
(All scenarios use AWIDTH=4, AE_LVL=2.)
1. Reset: pulse aclr_i with no clock -> rd_empty_o=1, rd_almost_empty_o=1, rd_usedw_o=0, rd_pntr_o=0, rd_pntr_gray_wr_o=5'b00000, rd_underflow_o=0.
2. Latency: wr_pntr_gray_i 00000->00001 -> rd_usedw_o=1 after the 2nd edge; rd_empty_o=0 after the 3rd edge; rd_almost_empty_o stays 1.
3. Drain a full FIFO:
   - Stimulus: wr_pntr_gray_i=5'b11000 (bin 16), then rd_req_i held for 16 cycles.
   - Before reading: rd_usedw_o=16.
   - During reading: rd_pntr_o steps 0..15 then 0; rd_almost_empty_o rises when usedw=2.
   - After the 16th read edge: rd_empty_o=1 on that same edge, rd_pntr_gray_wr_o=5'b11000.
4. Underflow: rd_req_i=1 while empty for 3 cycles -> rd_pntr_o unchanged, rd_underflow_o=1 and stays 1 after rd_req_i drops, until aclr_i.
5. Wrap: rd_pntr_bin=31 with wr bin=0 (gray 00000) and one read -> rd_pntr_bin=0, rd_pntr_gray_wr_o 10000->00000, rd_empty_o=1, rd_usedw_o=0.
6. Mid-operation reset: assert aclr_i asynchronously while usedw=7 and reads are in flight -> all outputs reach reset values before the next edge; after release, a 1-word write (gray 00001) empties out normally.

Source files
------------

// File: rtl/rd_pntrs_and_empty.sv
// -----------------------------------------------------------------------------
// rd_pntrs_and_empty
//
// Read-domain control stage of the dual-clock FIFO.
//   - Brings the Gray write pointer into the read clock domain through a
//     two-flop synchroniser and converts it to binary.
//   - Keeps the binary read pointer and its registered Gray copy. The Gray
//     copy is sent back to the write-side full logic.
//   - Produces the registered empty flag, the used-words count, the
//     almost-empty flag and a sticky underflow flag.
//
// Parameters
//   DWIDTH  data width. It is carried only so the hierarchy stays consistent;
//           no logic depends on it.
//   AWIDTH  RAM address width. FIFO depth is 2**AWIDTH, and the pointers are
//           AWIDTH+1 bits wide.
//   AE_LVL  almost-empty threshold in words, in the range 0..2**AWIDTH.
//
// Ports
//   rd_clk_i           in   read-domain clock, rising edge
//   aclr_i             in   asynchronous active-high reset
//   rd_req_i           in   read request; honoured only while not empty
//   wr_pntr_gray_i     in   Gray write pointer, asynchronous to rd_clk_i
//   rd_pntr_o          out  RAM read address (low AWIDTH bits of the binary pointer)
//   rd_pntr_gray_wr_o  out  registered Gray read pointer for the write domain
//   rd_empty_o         out  registered empty flag
//   rd_almost_empty_o  out  high while rd_usedw_o <= AE_LVL
//   rd_usedw_o         out  words available, 0..2**AWIDTH
//   rd_underflow_o     out  sticky; set when a read is attempted while empty
// -----------------------------------------------------------------------------
module rd_pntrs_and_empty #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4,
    parameter int AE_LVL = 2
) (
    input  logic              rd_clk_i,
    input  logic              aclr_i,
    input  logic              rd_req_i,
    input  logic [AWIDTH:0]   wr_pntr_gray_i,
    output logic [AWIDTH-1:0] rd_pntr_o,
    output logic [AWIDTH:0]   rd_pntr_gray_wr_o,
    output logic              rd_empty_o,
    output logic              rd_almost_empty_o,
    output logic [AWIDTH:0]   rd_usedw_o,
    output logic              rd_underflow_o
);

    localparam logic [AWIDTH:0] AE_LVL_W = (AWIDTH+1)'(AE_LVL);

    // Reject parameter values that cannot work, at elaboration time.
    if (DWIDTH < 1) begin : g_bad_dwidth
        $error("rd_pntrs_and_empty: DWIDTH must be at least 1");
    end
    if (AWIDTH < 1) begin : g_bad_awidth
        $error("rd_pntrs_and_empty: AWIDTH must be at least 1");
    end
    if ((AE_LVL < 0) || (AE_LVL > (1 << AWIDTH))) begin : g_bad_ae_lvl
        $error("rd_pntrs_and_empty: AE_LVL must be within 0..2**AWIDTH");
    end

    // Synchroniser stages, read pointer and status registers.
    logic [AWIDTH:0] r_sync1;
    logic [AWIDTH:0] r_sync2;
    logic [AWIDTH:0] r_rd_pntr_bin;
    logic [AWIDTH:0] r_rd_pntr_gray;
    logic            r_empty;
    logic            r_underflow;

    // Next-state and decoded values.
    logic            w_rd_en;
    logic [AWIDTH:0] w_rd_pntr_bin_next;
    logic [AWIDTH:0] w_rd_pntr_gray_next;
    logic [AWIDTH:0] w_wr_bin_sync;
    logic [AWIDTH:0] w_usedw;

    // Two-flop synchroniser. There must be no logic between the stages:
    // only one bit of the Gray input changes per write, so each stage
    // can only be one step behind.
    always_ff @(posedge rd_clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= wr_pntr_gray_i;
            r_sync2 <= r_sync1;
        end
    end

    // Gray to binary: bit i is the XOR of sync2[AWIDTH:i].
    always_comb begin
        w_wr_bin_sync = '0;
        for (int i = 0; i <= AWIDTH; i++) begin
            w_wr_bin_sync[i] = ^(r_sync2 >> i);
        end
    end

    // The read pointer only moves for a request made while not empty.
    // The pointer wraps naturally at 2**(AWIDTH+1).
    assign w_rd_en             = rd_req_i & ~r_empty;
    assign w_rd_pntr_bin_next  = r_rd_pntr_bin + {{AWIDTH{1'b0}}, w_rd_en};
    assign w_rd_pntr_gray_next = w_rd_pntr_bin_next ^ (w_rd_pntr_bin_next >> 1);

    // Empty is decided from the *next* read pointer. A read that takes the
    // last word therefore raises empty on the same edge. A stale sync2 can
    // only make empty look true too long, never too short.
    always_ff @(posedge rd_clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            r_rd_pntr_bin  <= '0;
            r_rd_pntr_gray <= '0;
            r_empty        <= 1'b1;
            r_underflow    <= 1'b0;
        end else begin
            r_rd_pntr_bin  <= w_rd_pntr_bin_next;
            r_rd_pntr_gray <= w_rd_pntr_gray_next;
            r_empty        <= (w_rd_pntr_gray_next == r_sync2);
            if (rd_req_i && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Both operands come from registers. With legal pointers the
    // difference stays within 0..2**AWIDTH.
    assign w_usedw = w_wr_bin_sync - r_rd_pntr_bin;

    assign rd_pntr_o         = r_rd_pntr_bin[AWIDTH-1:0];
    // Driven straight from a flop so it can be safely sampled by the write domain.
    assign rd_pntr_gray_wr_o = r_rd_pntr_gray;
    assign rd_empty_o        = r_empty;
    assign rd_usedw_o        = w_usedw;
    assign rd_almost_empty_o = (w_usedw <= AE_LVL_W);
    assign rd_underflow_o    = r_underflow;

endmodule

// File: tb/tb_rd_pntrs_and_empty.sv
module tb_rd_pntrs_and_empty;

    logic       clk_free = 1'b0;
    logic       clk_en   = 1'b0;
    logic       rd_clk;
    logic       aclr     = 1'b0;
    logic       rd_req   = 1'b0;
    logic [4:0] wr_gray  = 5'b00000;
    logic [3:0] rd_pntr;
    logic [4:0] rd_gray;
    logic       empty;
    logic       aempty;
    logic [4:0] usedw;
    logic       uflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_free = ~clk_free;
    assign rd_clk = clk_free & clk_en;

    rd_pntrs_and_empty #(.DWIDTH(8), .AWIDTH(4), .AE_LVL(2)) dut (
        .rd_clk_i          (rd_clk),
        .aclr_i            (aclr),
        .rd_req_i          (rd_req),
        .wr_pntr_gray_i    (wr_gray),
        .rd_pntr_o         (rd_pntr),
        .rd_pntr_gray_wr_o (rd_gray),
        .rd_empty_o        (empty),
        .rd_almost_empty_o (aempty),
        .rd_usedw_o        (usedw),
        .rd_underflow_o    (uflow)
    );

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic read_n(input int n);
        rd_req = 1'b1;
        repeat (n) tick();
        rd_req = 1'b0;
    endtask

    // Reset pulse with the clock stopped.
    task automatic test_reset();
        #2 aclr = 1'b1;
        #1;
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
        n_cmp++; if (aempty !== 1'b1) begin n_bad++; $display("FAIL rst_aempty got=%b exp=1", aempty); end
        n_cmp++; if (usedw !== 5'd0) begin n_bad++; $display("FAIL rst_usedw got=%0d exp=0", usedw); end
        n_cmp++; if (rd_pntr !== 4'd0) begin n_bad++; $display("FAIL rst_pntr got=%0d exp=0", rd_pntr); end
        n_cmp++; if (rd_gray !== 5'b00000) begin n_bad++; $display("FAIL rst_gray got=%b exp=00000", rd_gray); end
        n_cmp++; if (uflow !== 1'b0) begin n_bad++; $display("FAIL rst_uflow got=%b exp=0", uflow); end
        #2 aclr = 1'b0;
        @(negedge clk_free);
        clk_en = 1'b1;
    endtask

    // A single write becomes visible: usedw after 2 edges, empty falls after 3.
    task automatic test_latency();
        wr_gray = 5'b00001;
        tick();
        n_cmp++; if (usedw !== 5'd0) begin n_bad++; $display("FAIL lat_usedw_e1 got=%0d exp=0", usedw); end
        tick();
        n_cmp++; if (usedw !== 5'd1) begin n_bad++; $display("FAIL lat_usedw_e2 got=%0d exp=1", usedw); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL lat_empty_e2 got=%b exp=1", empty); end
        tick();
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL lat_empty_e3 got=%b exp=0", empty); end
        n_cmp++; if (aempty !== 1'b1) begin n_bad++; $display("FAIL lat_aempty got=%b exp=1", aempty); end
    endtask

    // Fill to 16 words, then drain with back-to-back reads.
    task automatic test_drain_full();
        wr_gray = 5'b11000;
        repeat (3) tick();
        n_cmp++; if (usedw !== 5'd16) begin n_bad++; $display("FAIL full_usedw got=%0d exp=16", usedw); end
        n_cmp++; if (aempty !== 1'b0) begin n_bad++; $display("FAIL full_aempty got=%b exp=0", aempty); end
        rd_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (rd_pntr !== 4'(i)) begin n_bad++; $display("FAIL drain_pntr[%0d] got=%0d exp=%0d", i, rd_pntr, i); end
            n_cmp++; if (usedw !== 5'(16 - i)) begin n_bad++; $display("FAIL drain_usedw[%0d] got=%0d exp=%0d", i, usedw, 16 - i); end
            n_cmp++; if (aempty !== ((16 - i) <= 2)) begin n_bad++; $display("FAIL drain_aempty[%0d] got=%b exp=%b", i, aempty, ((16 - i) <= 2)); end
            n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL drain_empty[%0d] got=%b exp=0", i, empty); end
            tick();
        end
        rd_req = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL drained_empty got=%b exp=1", empty); end
        n_cmp++; if (rd_pntr !== 4'd0) begin n_bad++; $display("FAIL drained_pntr got=%0d exp=0", rd_pntr); end
        n_cmp++; if (rd_gray !== 5'b11000) begin n_bad++; $display("FAIL drained_gray got=%b exp=11000", rd_gray); end
        n_cmp++; if (usedw !== 5'd0) begin n_bad++; $display("FAIL drained_usedw got=%0d exp=0", usedw); end
        n_cmp++; if (uflow !== 1'b0) begin n_bad++; $display("FAIL drained_uflow got=%b exp=0", uflow); end
    endtask

    // Reads while empty: the pointer holds and the flag sticks until reset.
    task automatic test_underflow();
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (rd_pntr !== 4'd0) begin n_bad++; $display("FAIL uf_pntr[%0d] got=%0d exp=0", i, rd_pntr); end
            n_cmp++; if (uflow !== 1'b1) begin n_bad++; $display("FAIL uf_flag[%0d] got=%b exp=1", i, uflow); end
            n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL uf_empty[%0d] got=%b exp=1", i, empty); end
        end
        rd_req = 1'b0;
        repeat (2) tick();
        n_cmp++; if (uflow !== 1'b1) begin n_bad++; $display("FAIL uf_sticky got=%b exp=1", uflow); end
        #2 aclr = 1'b1;
        #1;
        n_cmp++; if (uflow !== 1'b0) begin n_bad++; $display("FAIL uf_cleared got=%b exp=0", uflow); end
        n_cmp++; if (rd_gray !== 5'b00000) begin n_bad++; $display("FAIL uf_rst_gray got=%b exp=00000", rd_gray); end
        #1 aclr = 1'b0;
    endtask

    // Walk the read pointer up to 31, then take one word across the full wrap.
    task automatic test_wrap();
        // The write pointer is still 16 (gray 11000).
        repeat (3) tick();
        n_cmp++; if (usedw !== 5'd16) begin n_bad++; $display("FAIL wrap_fill16 got=%0d exp=16", usedw); end
        read_n(16);
        wr_gray = 5'b10000;  // binary 31
        repeat (3) tick();
        n_cmp++; if (usedw !== 5'd15) begin n_bad++; $display("FAIL wrap_usedw15 got=%0d exp=15", usedw); end
        read_n(15);
        n_cmp++; if (rd_gray !== 5'b10000) begin n_bad++; $display("FAIL wrap_gray31 got=%b exp=10000", rd_gray); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty31 got=%b exp=1", empty); end
        wr_gray = 5'b00000;  // binary 0: one word after pointer 31
        repeat (3) tick();
        n_cmp++; if (usedw !== 5'd1) begin n_bad++; $display("FAIL wrap_usedw1 got=%0d exp=1", usedw); end
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL wrap_notempty got=%b exp=0", empty); end
        n_cmp++; if (rd_pntr !== 4'd15) begin n_bad++; $display("FAIL wrap_pntr15 got=%0d exp=15", rd_pntr); end
        read_n(1);
        n_cmp++; if (rd_pntr !== 4'd0) begin n_bad++; $display("FAIL wrap_pntr0 got=%0d exp=0", rd_pntr); end
        n_cmp++; if (rd_gray !== 5'b00000) begin n_bad++; $display("FAIL wrap_gray0 got=%b exp=00000", rd_gray); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
        n_cmp++; if (usedw !== 5'd0) begin n_bad++; $display("FAIL wrap_usedw0 got=%0d exp=0", usedw); end
        n_cmp++; if (uflow !== 1'b0) begin n_bad++; $display("FAIL wrap_uflow got=%b exp=0", uflow); end
    endtask

    // Asynchronous reset in the middle of a read burst, then normal operation.
    task automatic test_midop_reset();
        wr_gray = 5'b01100;  // binary 8
        repeat (3) tick();
        n_cmp++; if (usedw !== 5'd8) begin n_bad++; $display("FAIL mid_usedw8 got=%0d exp=8", usedw); end
        rd_req = 1'b1;
        tick();
        n_cmp++; if (usedw !== 5'd7) begin n_bad++; $display("FAIL mid_usedw7 got=%0d exp=7", usedw); end
        #3 aclr = 1'b1;
        #1;
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL mid_empty got=%b exp=1", empty); end
        n_cmp++; if (aempty !== 1'b1) begin n_bad++; $display("FAIL mid_aempty got=%b exp=1", aempty); end
        n_cmp++; if (usedw !== 5'd0) begin n_bad++; $display("FAIL mid_usedw got=%0d exp=0", usedw); end
        n_cmp++; if (rd_pntr !== 4'd0) begin n_bad++; $display("FAIL mid_pntr got=%0d exp=0", rd_pntr); end
        n_cmp++; if (rd_gray !== 5'b00000) begin n_bad++; $display("FAIL mid_gray got=%b exp=00000", rd_gray); end
        n_cmp++; if (uflow !== 1'b0) begin n_bad++; $display("FAIL mid_uflow got=%b exp=0", uflow); end
        rd_req  = 1'b0;
        wr_gray = 5'b00001;
        #2 aclr = 1'b0;
        repeat (3) tick();
        n_cmp++; if (usedw !== 5'd1) begin n_bad++; $display("FAIL post_usedw1 got=%0d exp=1", usedw); end
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL post_notempty got=%b exp=0", empty); end
        read_n(1);
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL post_empty got=%b exp=1", empty); end
        n_cmp++; if (usedw !== 5'd0) begin n_bad++; $display("FAIL post_usedw0 got=%0d exp=0", usedw); end
        n_cmp++; if (rd_pntr !== 4'd1) begin n_bad++; $display("FAIL post_pntr got=%0d exp=1", rd_pntr); end
        n_cmp++; if (rd_gray !== 5'b00001) begin n_bad++; $display("FAIL post_gray got=%b exp=00001", rd_gray); end
        n_cmp++; if (uflow !== 1'b0) begin n_bad++; $display("FAIL post_uflow got=%b exp=0", uflow); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_drain_full();
        test_underflow();
        test_wrap();
        test_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
